alu_operand_loader: RTL and testbench

- Upstream feeder for the add/sub/AND/OR ALU top.
- Captures operand A, operand B and the 2-bit operation select from board switches, using three push-buttons.
- Enforces the load order A -> B -> op, then pulses o_valid for one cycle.
- o_dataA, o_dataB and o_sel connect directly to the ALU's i_dataA, i_dataB and i_sel, and hold between loads.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/alu_operand_loader.sv | 91 +++++++++
 tb/tb_alu_operand_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand loader and the ALU top:
// loader FSM states, push-button indices and ALU operation codes.
package alu_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, stable-count debounce and a
// single-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Stage p0/p1: metastability synchronizer for the raw button
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= i_btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level follows only after DB_CYCLES consecutive mismatches;
  // the press pulse is registered on the same edge the level rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
    end else if (sync_p1 == o_level) begin
      cnt     <= '0;
      o_press <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      o_level <= sync_p1;
      o_press <= sync_p1;
    end else begin
      cnt     <= cnt + CW'(1);
      o_press <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Loads operand A, operand B and the op select from switches in strict
// A -> B -> op order using three debounced buttons, then pulses o_valid.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int NB_size   = 16,
  parameter int DB_CYCLES = 1000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic        [NB_size-1:0] i_sw,
  input  logic        [2:0]         i_btn,
  output logic signed [NB_size-1:0] o_dataA,
  output logic signed [NB_size-1:0] o_dataB,
  output logic        [1:0]         o_sel,
  output logic                      o_valid,
  output logic        [1:0]         o_state
);

  logic [NB_size-1:0] sw_p0;
  logic [NB_size-1:0] sw_p1;
  logic [2:0]         level;
  logic [2:0]         press;
  logic [2:0]         go;
  state_t             state;

  // Stage p0/p1: switch synchronizer, no debounce (switches are static at load time)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= i_sw;
      sw_p1 <= sw_p0;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (i_btn[i]),
      .o_level(level[i]),
      .o_press(press[i])
    );
  end

  // A press is only honoured while its debounced level is actually high.
  assign go = press & level;

  // Load sequencer: out-of-order presses are dropped, never queued
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= WAIT_A;
      o_dataA <= '0;
      o_dataB <= '0;
      o_sel   <= 2'b00;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        WAIT_A: begin
          if (go[BTN_A]) begin
            o_dataA <= sw_p1;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (go[BTN_B]) begin
            o_dataB <= sw_p1;
            state   <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (go[BTN_OP]) begin
            o_sel   <= sw_p1[1:0];
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE:    state <= WAIT_A;
        default: state <= WAIT_A;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized and directed bench for alu_operand_loader against a
// sample-window reference model of debounce and load sequencing.
module tb_alu_operand_loader;

  localparam int NB = 16;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] sw;
  logic [2:0]    btn;
  logic [NB-1:0] data_a;
  logic [NB-1:0] data_b;
  logic [1:0]    sel;
  logic          valid;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  // Reference model state
  logic [NB-1:0] m_sw1, m_sw2;
  logic [2:0]    m_b1, m_b2;
  logic [DB-1:0] m_win [3];
  logic [2:0]    m_lvl, m_press;
  int            m_phase;
  logic [NB-1:0] m_a, m_b;
  logic [1:0]    m_sel;

  alu_operand_loader #(
    .NB_size  (NB),
    .DB_CYCLES(DB)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sw   (sw),
    .i_btn  (btn),
    .o_dataA(data_a),
    .o_dataB(data_b),
    .o_sel  (sel),
    .o_valid(valid),
    .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
    for (int b = 0; b < 3; b++) m_win[b] = '0;
    m_lvl = '0; m_press = '0; m_phase = 0;
    m_a = '0; m_b = '0; m_sel = '0;
  endtask

  // Level flips when the last DB synchronized samples all disagree with it.
  task automatic m_step();
    logic [2:0]    pr_old;
    logic [2:0]    pr_new;
    logic [NB-1:0] swv;
    if (rst) begin
      m_reset();
      return;
    end
    pr_old = m_press;
    swv    = m_sw2;
    pr_new = '0;
    for (int b = 0; b < 3; b++) begin
      m_win[b] = {m_win[b][DB-2:0], m_b2[b]};
      if (m_win[b] == {DB{~m_lvl[b]}}) begin
        m_lvl[b]  = ~m_lvl[b];
        pr_new[b] = m_lvl[b];
      end
    end
    m_b2 = m_b1; m_b1 = btn;
    m_sw2 = m_sw1; m_sw1 = sw;
    case (m_phase)
      0: if (pr_old[0]) begin m_a = swv; m_phase = 1; end
      1: if (pr_old[1]) begin m_b = swv; m_phase = 2; end
      2: if (pr_old[2]) begin m_sel = swv[1:0]; m_phase = 3; end
      default: m_phase = 0;
    endcase
    m_press = pr_new;
  endtask

  task automatic cmp_model(input string pfx);
    chk({pfx, "_dataA"}, 32'(data_a), 32'(m_a));
    chk({pfx, "_dataB"}, 32'(data_b), 32'(m_b));
    chk({pfx, "_sel"},   32'(sel),    32'(m_sel));
    chk({pfx, "_valid"}, 32'(valid),  32'(m_phase == 3));
    chk({pfx, "_state"}, 32'(state),  32'(m_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    cmp_model("m");
    if (valid) vcount++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = '0;
    m_reset();
    #1;
    chk("rst_dataA", 32'(data_a), 32'h0);
    chk("rst_dataB", 32'(data_b), 32'h0);
    chk("rst_sel",   32'(sel),    32'h0);
    chk("rst_valid", 32'(valid),  32'h0);
    chk("rst_state", 32'(state),  32'h0);
    tick();
    rst = 1'b0;
    vcount = 0;
  endtask

  task automatic press(input int b, input logic [NB-1:0] v);
    sw = v;
    hold(3);
    btn[b] = 1'b1;
    hold(10);
    btn[b] = 1'b0;
    hold(10);
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    btn = '0;
    m_reset();

    // 1: basic A -> B -> op sequence
    do_reset();
    press(0, 16'h0005);
    press(1, 16'hFFFD);
    press(2, 16'h0001);
    chk("t1_dataA", 32'(data_a), 32'h0005);
    chk("t1_dataB", 32'(data_b), 32'hFFFD);
    chk("t1_sel",   32'(sel),    32'h1);
    chk("t1_state", 32'(state),  32'h0);
    chk("t1_vcnt",  vcount,      1);

    // 2: short glitch ignored, then exact press latency
    do_reset();
    sw = 16'h1234;
    hold(3);
    btn[0] = 1'b1;
    hold(3);
    btn[0] = 1'b0;
    hold(10);
    chk("t2_glitch_state", 32'(state),  32'h0);
    chk("t2_glitch_dataA", 32'(data_a), 32'h0);
    btn[0] = 1'b1;
    hold(6);
    chk("t2_edge6", 32'(data_a), 32'h0);
    tick();
    chk("t2_edge7", 32'(data_a), 32'h1234);
    btn[0] = 1'b0;
    hold(10);

    // 3: out-of-order and simultaneous presses in WAIT_A
    do_reset();
    press(1, 16'hAAAA);
    press(2, 16'h0003);
    sw = 16'h5555;
    hold(3);
    btn = 3'b110;
    hold(10);
    btn = 3'b000;
    hold(10);
    chk("t3_state", 32'(state),  32'h0);
    chk("t3_dataB", 32'(data_b), 32'h0);
    chk("t3_sel",   32'(sel),    32'h0);
    press(0, 16'h1111);
    chk("t3_stateA", 32'(state),  32'h1);
    chk("t3_dataA",  32'(data_a), 32'h1111);

    // 4: bounce burst on button A
    do_reset();
    sw = 16'h0ABC;
    hold(3);
    for (int i = 0; i < 12; i++) begin
      btn[0] = ~btn[0];
      tick();
    end
    btn[0] = 1'b1;
    hold(10);
    btn[0] = 1'b0;
    hold(10);
    chk("t4_state", 32'(state),  32'h1);
    chk("t4_dataA", 32'(data_a), 32'h0ABC);

    // 5: reset during WAIT_OP, then a clean sequence
    do_reset();
    press(0, 16'h0003);
    press(1, 16'h0004);
    chk("t5_pre_state", 32'(state), 32'h2);
    do_reset();
    press(0, 16'h0009);
    press(1, 16'h0008);
    press(2, 16'h0002);
    chk("t5_dataA", 32'(data_a), 32'h0009);
    chk("t5_dataB", 32'(data_b), 32'h0008);
    chk("t5_sel",   32'(sel),    32'h2);
    chk("t5_vcnt",  vcount,      1);

    // 6: back-to-back sequences, outputs hold until reloaded
    do_reset();
    press(0, 16'h7FFF);
    press(1, 16'h0001);
    press(2, 16'h0000);
    press(0, 16'h8000);
    chk("t6_dataA", 32'(data_a), 32'h8000);
    chk("t6_dataB", 32'(data_b), 32'h0001);
    chk("t6_sel",   32'(sel),    32'h0);
    chk("t6_state", 32'(state),  32'h1);
    press(1, 16'h0002);
    press(2, 16'hFFFF);
    chk("t6_sel2",  32'(sel),    32'h3);
    chk("t6_vcnt",  vcount,      2);

    // Random button activity, model checked every cycle
    do_reset();
    for (int s = 0; s < 120; s++) begin
      sw = NB'($urandom);
      case ($urandom_range(0, 5))
        0:       btn = 3'($urandom);
        1:       btn = '0;
        default: btn = 3'b001 << $urandom_range(0, 2);
      endcase
      hold($urandom_range(1, 14));
      if ($urandom_range(0, 40) == 0) do_reset();
    end
    btn = '0;
    hold(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
